fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences the fetch pipeline: owns the even/odd fetch line pointers (FIP_e/FIP_o)
//  that drive fetch_1 and the iBuff latch, and selects the next pair among init,
//  writeback resteer, branch-predictor target and sequential advance.
//  Holds the pair on I$ miss or iBuff backpressure, flushes the iBuff on redirect,
//  and counts miss-stall cycles.
// PARAMETERS
//  FIP_W   28  line-pointer width (32-bit byte addr >> 4, 16B lines)
//  CNT_W   16  width of saturating miss-stall counter
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high reset
//  is_init        in   1      load start pair from init_addr
//  init_addr      in   32     start byte address
//  resteer        in   1      writeback redirect
//  WB_FIP_e       in   FIP_W  resteer even line
//  WB_FIP_o       in   FIP_W  resteer odd line
//  BP_taken       in   1      predictor redirect valid (same cycle as current pair)
//  BP_FIP_e       in   FIP_W  predicted even line
//  BP_FIP_o       in   FIP_W  predicted odd line
//  cache_miss_e   in   1      even-line I$ miss on current pair
//  cache_miss_o   in   1      odd-line I$ miss on current pair
//  ibuf_ready     in   1      iBuff can accept a line pair this cycle
//  FIP_e          out  FIP_W  current even line pointer
//  FIP_o          out  FIP_W  current odd line pointer
//  fetch_valid    out  1      FIP_e/FIP_o are a live request
//  stall          out  1      pair held (miss or backpressure)
//  flush_ibuf     out  1      1-cycle pulse: invalidate iBuff contents
//  miss_cycles    out  CNT_W  cycles spent in MISS, saturating
// BEHAVIOUR
//  All outputs registered. Reset: state=IDLE, FIP_e=FIP_o=0, fetch_valid=0, stall=0,
//   flush_ibuf=0, miss_cycles=0; reset mid-MISS/REDIR aborts immediately.
//  States: IDLE, REDIR, RUN, MISS. fetch_valid=1 in RUN and MISS only.
//  Pair load from line L: L even -> FIP_e=L, FIP_o=L+1; L odd -> FIP_o=L, FIP_e=L+1
//   (all arithmetic mod 2^FIP_W). Sequential advance adds 2 to both pointers.
//  Priority per cycle: reset > resteer > is_init > miss > BP_taken > sequential.
//  resteer (any state): load WB_FIP_e/o verbatim, flush_ibuf=1 next cycle, -> REDIR.
//  is_init (any state, no resteer): load pair from L=init_addr[31:4], flush_ibuf=1,
//   -> REDIR. IDLE ignores all other inputs.
//  REDIR: fetch_valid=0 for exactly 1 cycle, then -> RUN (resteer again restarts REDIR).
//  RUN: accept = ~cache_miss_e & ~cache_miss_o & ibuf_ready.
//   miss (either) -> MISS, pointers held, stall=1.
//   no miss, ~ibuf_ready -> stay RUN, pointers held, stall=1.
//   accept & BP_taken -> load BP_FIP_e/o; accept & ~BP_taken -> advance +2; stall=0.
//  MISS: pointers held, stall=1, miss_cycles+1 per cycle (saturate at all-ones).
//   Both miss lines low -> RUN, no advance on exit cycle; BP_taken ignored in MISS.
//  Pointer wrap: 0xFFFFFFE -> 0x0000000 (even), 0xFFFFFFF -> 0x0000001 (odd), no flag.
//  flush_ibuf never asserted except the cycle after a resteer/is_init capture.
// TESTING
//  reset 3 cycles -> all outputs 0, IDLE; BP_taken/resteer ignored in IDLE except resteer
//  is_init, init_addr=0x00001230 -> REDIR w/ FIP_e=0x123? no: L=0x0000123 odd -> FIP_o=0x0000123,
//   FIP_e=0x0000124, flush 1 cycle, then RUN; 3 accepts -> FIP_o=0x0000129
//  RUN, cache_miss_o=1 for 4 cycles -> pointers held, stall=1, miss_cycles=4, no advance on exit
//  accept with BP_taken, BP_FIP_e=0x0000400/o=0x0000401 same cycle as resteer WB_FIP_e=0x0000800
//   -> resteer wins, FIP_e=0x0000800, flush_ibuf=1, REDIR
//  FIP_e=0xFFFFFFE, FIP_o=0xFFFFFFF, accept -> 0x0000000/0x0000001
//  ibuf_ready=0 in RUN -> stall=1, no miss_cycles increment; CNT_W=4 with 20 miss cycles -> 0xF

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the even/odd fetch line-pointer pair and sequences the
// fetch pipeline through IDLE / REDIR / RUN / MISS. Picks the next pair from
// writeback resteer, init, branch-predictor target or sequential +2 advance,
// holds the pair on I$ miss or iBuff backpressure, pulses an iBuff flush after
// every redirect capture and counts miss-stall cycles (saturating).
module fetch_ctrl #(
    parameter int FIP_W = 28,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             is_init,
    input  logic [31:0]      init_addr,
    input  logic             resteer,
    input  logic [FIP_W-1:0] WB_FIP_e,
    input  logic [FIP_W-1:0] WB_FIP_o,
    input  logic             BP_taken,
    input  logic [FIP_W-1:0] BP_FIP_e,
    input  logic [FIP_W-1:0] BP_FIP_o,
    input  logic             cache_miss_e,
    input  logic             cache_miss_o,
    input  logic             ibuf_ready,
    output logic [FIP_W-1:0] FIP_e,
    output logic [FIP_W-1:0] FIP_o,
    output logic             fetch_valid,
    output logic             stall,
    output logic             flush_ibuf,
    output logic [CNT_W-1:0] miss_cycles
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REDIR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_MISS  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [FIP_W-1:0] fip_e_nxt;
    logic [FIP_W-1:0] fip_o_nxt;
    logic             stall_nxt;
    logic             flush_nxt;
    logic             valid_nxt;
    logic [CNT_W-1:0] miss_cycles_nxt;

    logic [FIP_W-1:0] init_line;
    logic             any_miss;
    logic             accept;

    // Start line is the 16B-line index of the init byte address.
    assign init_line = FIP_W'(init_addr[31:4]);
    assign any_miss  = cache_miss_e | cache_miss_o;
    assign accept    = ~any_miss & ibuf_ready;

    // Next-state, next-pointer and status selection in priority order.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_nxt = state;
        fip_e_nxt = FIP_e;
        fip_o_nxt = FIP_o;
        stall_nxt = stall;
        flush_nxt = 1'b0;

        if (resteer) begin
            // Writeback redirect: pair is taken verbatim.
            fip_e_nxt = WB_FIP_e;
            fip_o_nxt = WB_FIP_o;
            flush_nxt = 1'b1;
            stall_nxt = 1'b0;
            state_nxt = S_REDIR;
        end else if (is_init) begin
            // The start line lands in whichever slot matches its parity;
            // the other slot gets the following line.
            if (init_line[0]) begin
                fip_o_nxt = init_line;
                fip_e_nxt = init_line + FIP_W'(1);
            end else begin
                fip_e_nxt = init_line;
                fip_o_nxt = init_line + FIP_W'(1);
            end
            flush_nxt = 1'b1;
            stall_nxt = 1'b0;
            state_nxt = S_REDIR;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_IDLE;
                end
                S_REDIR: begin
                    // One dead cycle lets the iBuff flush settle before fetch resumes.
                    state_nxt = S_RUN;
                    stall_nxt = 1'b0;
                end
                S_RUN: begin
                    if (any_miss) begin
                        state_nxt = S_MISS;
                        stall_nxt = 1'b1;
                    end else if (!ibuf_ready) begin
                        stall_nxt = 1'b1;
                    end else begin
                        stall_nxt = 1'b0;
                        if (BP_taken) begin
                            fip_e_nxt = BP_FIP_e;
                            fip_o_nxt = BP_FIP_o;
                        end else begin
                            fip_e_nxt = FIP_e + FIP_W'(2);
                            fip_o_nxt = FIP_o + FIP_W'(2);
                        end
                    end
                end
                S_MISS: begin
                    // The missing pair is re-presented, so leaving MISS does not advance.
                    if (any_miss) begin
                        stall_nxt = 1'b1;
                    end else begin
                        state_nxt = S_RUN;
                        stall_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    stall_nxt = 1'b0;
                end
            endcase
        end
    end

    // Requests are live only while running or waiting on a miss.
    assign valid_nxt = (state_nxt == S_RUN) || (state_nxt == S_MISS);

    // Every cycle spent in MISS is counted; the counter sticks at all-ones.
    always_comb begin
        miss_cycles_nxt = miss_cycles;
        if ((state == S_MISS) && (miss_cycles != {CNT_W{1'b1}})) begin
            miss_cycles_nxt = miss_cycles + CNT_W'(1);
        end
    end

    // All outputs are registered; reset aborts any state immediately.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= S_IDLE;
            FIP_e       <= '0;
            FIP_o       <= '0;
            fetch_valid <= 1'b0;
            stall       <= 1'b0;
            flush_ibuf  <= 1'b0;
            miss_cycles <= '0;
        end else begin
            state       <= state_nxt;
            FIP_e       <= fip_e_nxt;
            FIP_o       <= fip_o_nxt;
            fetch_valid <= valid_nxt;
            stall       <= stall_nxt;
            flush_ibuf  <= flush_nxt;
            miss_cycles <= miss_cycles_nxt;
        end
    end

    // accept is the RUN-state handshake; kept as a named term for readability.
    logic unused_ok;
    assign unused_ok = accept;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic,
// expected outputs from a behavioural model pushed into a scoreboard queue and
// compared by an independent monitor. A second instance with a 4-bit counter
// exercises saturation.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        is_init;
    logic [31:0] init_addr;
    logic        resteer;
    logic [27:0] wb_fip_e, wb_fip_o;
    logic        bp_taken;
    logic [27:0] bp_fip_e, bp_fip_o;
    logic        cache_miss_e, cache_miss_o;
    logic        ibuf_ready;

    logic [27:0] fip_e, fip_o;
    logic        fetch_valid, stall, flush_ibuf;
    logic [15:0] miss_cycles;

    logic [27:0] s_fip_e, s_fip_o;
    logic        s_valid, s_stall, s_flush;
    logic [3:0]  s_miss_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.FIP_W(28), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .is_init(is_init), .init_addr(init_addr),
        .resteer(resteer), .WB_FIP_e(wb_fip_e), .WB_FIP_o(wb_fip_o),
        .BP_taken(bp_taken), .BP_FIP_e(bp_fip_e), .BP_FIP_o(bp_fip_o),
        .cache_miss_e(cache_miss_e), .cache_miss_o(cache_miss_o), .ibuf_ready(ibuf_ready),
        .FIP_e(fip_e), .FIP_o(fip_o), .fetch_valid(fetch_valid), .stall(stall),
        .flush_ibuf(flush_ibuf), .miss_cycles(miss_cycles)
    );

    fetch_ctrl #(.FIP_W(28), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .is_init(is_init), .init_addr(init_addr),
        .resteer(resteer), .WB_FIP_e(wb_fip_e), .WB_FIP_o(wb_fip_o),
        .BP_taken(bp_taken), .BP_FIP_e(bp_fip_e), .BP_FIP_o(bp_fip_o),
        .cache_miss_e(cache_miss_e), .cache_miss_o(cache_miss_o), .ibuf_ready(ibuf_ready),
        .FIP_e(s_fip_e), .FIP_o(s_fip_o), .fetch_valid(s_valid), .stall(s_stall),
        .flush_ibuf(s_flush), .miss_cycles(s_miss_cycles)
    );

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_REDIR, M_RUN, M_MISS} mode_t;

    typedef struct {
        logic [27:0] e;
        logic [27:0] o;
        logic        v;
        logic        s;
        logic        f;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sb[$];
    mode_t       m_mode  = M_IDLE;
    logic [27:0] m_e     = '0;
    logic [27:0] m_o     = '0;
    int unsigned m_cnt   = 0;
    logic        m_stall = 1'b0;
    logic        m_flush = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one clock's worth of rules to the model and queue the outcome.
    task automatic model_step();
        logic [27:0] line;
        exp_t x;
        if (reset) begin
            m_mode = M_IDLE; m_e = '0; m_o = '0; m_cnt = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_mode == M_MISS) m_cnt++;
            m_flush = 0;
            if (resteer) begin
                m_e = wb_fip_e; m_o = wb_fip_o;
                m_flush = 1; m_stall = 0; m_mode = M_REDIR;
            end else if (is_init) begin
                line = init_addr[31:4];
                if (line % 2 == 0) begin m_e = line; m_o = line + 1; end
                else               begin m_o = line; m_e = line + 1; end
                m_flush = 1; m_stall = 0; m_mode = M_REDIR;
            end else if (m_mode == M_REDIR) begin
                m_mode = M_RUN; m_stall = 0;
            end else if (m_mode == M_RUN) begin
                if (cache_miss_e || cache_miss_o) begin
                    m_mode = M_MISS; m_stall = 1;
                end else if (!ibuf_ready) begin
                    m_stall = 1;
                end else if (bp_taken) begin
                    m_e = bp_fip_e; m_o = bp_fip_o; m_stall = 0;
                end else begin
                    m_e = m_e + 2; m_o = m_o + 2; m_stall = 0;
                end
            end else if (m_mode == M_MISS) begin
                if (cache_miss_e || cache_miss_o) m_stall = 1;
                else begin m_mode = M_RUN; m_stall = 0; end
            end
        end
        x.e    = m_e;
        x.o    = m_o;
        x.v    = (m_mode == M_RUN) || (m_mode == M_MISS);
        x.s    = m_stall;
        x.f    = m_flush;
        x.cnt  = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        x.cnt4 = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
        sb.push_back(x);
    endtask

    // Monitor: compares every registered output shortly after each edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("FIP_e",       fip_e,         x.e);
                check("FIP_o",       fip_o,         x.o);
                check("fetch_valid", fetch_valid,   x.v);
                check("stall",       stall,         x.s);
                check("flush_ibuf",  flush_ibuf,    x.f);
                check("miss_cycles", miss_cycles,   x.cnt);
                check("miss_cycles4", s_miss_cycles, x.cnt4);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic quiet();
        reset = 0; is_init = 0; init_addr = '0; resteer = 0;
        wb_fip_e = '0; wb_fip_o = '0; bp_taken = 0; bp_fip_e = '0; bp_fip_o = '0;
        cache_miss_e = 0; cache_miss_o = 0; ibuf_ready = 1;
    endtask

    initial begin
        quiet();
        reset = 1;
        repeat (3) tick();
        check("reset_valid", fetch_valid, 1'b0);
        check("reset_fip_e", fip_e, 28'h0);
        check("reset_cnt", miss_cycles, 16'h0);
        reset = 0;

        // IDLE ignores predictor and miss inputs.
        bp_taken = 1; bp_fip_e = 28'h400; bp_fip_o = 28'h401; cache_miss_e = 1;
        repeat (2) tick();
        check("idle_ignore_bp", fip_e, 28'h0);
        check("idle_stall", stall, 1'b0);
        quiet();

        // Init from an odd start line.
        is_init = 1; init_addr = 32'h0000_1230;
        tick();
        quiet();
        check("init_fip_o", fip_o, 28'h123);
        check("init_fip_e", fip_e, 28'h124);
        check("init_flush", flush_ibuf, 1'b1);
        check("redir_invalid", fetch_valid, 1'b0);
        tick();
        check("run_flush_clear", flush_ibuf, 1'b0);
        check("run_valid", fetch_valid, 1'b1);
        repeat (3) tick();
        check("three_accepts", fip_o, 28'h129);

        // Odd-line miss for 4 cycles, then exit without advance.
        cache_miss_o = 1;
        repeat (4) tick();
        check("miss_stall", stall, 1'b1);
        cache_miss_o = 0;
        tick();
        check("miss_count4", miss_cycles, 16'd4);
        check("miss_no_adv", fip_o, 28'h129);

        // Backpressure holds without counting.
        ibuf_ready = 0;
        repeat (2) tick();
        check("bp_stall", stall, 1'b1);
        check("bp_no_count", miss_cycles, 16'd4);
        ibuf_ready = 1;

        // Resteer beats a simultaneous predictor redirect.
        resteer = 1; wb_fip_e = 28'h800; wb_fip_o = 28'h801;
        bp_taken = 1; bp_fip_e = 28'h400; bp_fip_o = 28'h401;
        tick();
        quiet();
        check("resteer_wins", fip_e, 28'h800);
        check("resteer_flush", flush_ibuf, 1'b1);
        tick();

        // Pointer wrap on sequential advance.
        resteer = 1; wb_fip_e = 28'hFFFFFFE; wb_fip_o = 28'hFFFFFFF;
        tick();
        quiet();
        tick();
        tick();
        check("wrap_e", fip_e, 28'h0);
        check("wrap_o", fip_o, 28'h1);

        // 20 cycles spent in MISS: small counter saturates.
        cache_miss_e = 1;
        repeat (20) tick();
        cache_miss_e = 0;
        tick();
        check("sat_cnt4", s_miss_cycles, 4'hF);
        check("cnt16_total", miss_cycles, 16'd24);

        // Reset mid-MISS aborts at once.
        cache_miss_e = 1;
        tick();
        reset = 1;
        tick();
        quiet();
        check("abort_valid", fetch_valid, 1'b0);
        check("abort_cnt", miss_cycles, 16'h0);
        check("abort_stall", stall, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(99) < 1);
            resteer      = ($urandom_range(99) < 3);
            is_init      = ($urandom_range(99) < 4);
            init_addr    = $urandom;
            wb_fip_e     = 28'($urandom);
            wb_fip_o     = 28'($urandom);
            bp_taken     = ($urandom_range(99) < 20);
            bp_fip_e     = 28'($urandom);
            bp_fip_o     = 28'($urandom);
            cache_miss_e = ($urandom_range(99) < 12);
            cache_miss_o = ($urandom_range(99) < 12);
            ibuf_ready   = ($urandom_range(99) < 80);
            tick();
        end
        quiet();

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
